dmem_bridge: RTL
================

Name: dmem_bridge

Overview:
- MEM-stage data-memory access unit between the 5-stage pipeline datapath and a word-wide external data bus with request/acknowledge handshake.
- Consumes the datapath's MEM-stage memory request (valid, ren, wen, addr, write data) and returns read data for WB capture.
- Raises a stall to the pipeline controller while a bus transaction is outstanding.
- Detects misaligned accesses, bus errors and bus timeouts, reporting each through sticky flags.

Parameters:
- TIMEOUT, 16: BUSY cycles without bus_ack before the access is aborted; legal range 2..255.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  main clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_ren  in  1  load request from MEM stage
- mem_wen  in  1  store request from MEM stage
- mem_addr  in  32  byte address from MEM stage (ALU result)
- mem_dout  in  32  store data from MEM stage
- mem_din  out  32  load data to datapath, sampled by WB
- mem_stall  out  1  high while the current MEM access is incomplete; controller freezes IF..MEM and bubbles WB
- bus_req  out  1  bus request, registered
- bus_we  out  1  1 = write, registered
- bus_addr  out  32  word-aligned bus address, registered
- bus_wdata  out  32  bus write data, registered
- bus_ack  in  1  one-cycle transaction completion
- bus_rdata  in  32  read data, valid with bus_ack
- bus_err  in  1  error, valid with bus_ack
- err_misalign  out  1  sticky: access with mem_addr[1:0] != 0
- err_bus  out  1  sticky: bus_ack with bus_err
- err_timeout  out  1  sticky: TIMEOUT reached

Behaviour:
- Reset (async, rst_n low): state IDLE. All of the following clear to 0: bus_req, bus_we, bus_addr, bus_wdata, mem_din, mem_stall, all err_* flags, timeout counter.
- A reset asserted mid-transaction drops bus_req at once. A late bus_ack arriving after reset is ignored.
- Access condition: acc = mem_valid & (mem_ren | mem_wen).
- If both mem_ren and mem_wen are set, the access is treated as a write.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - mem_stall = acc, combinational.
  - If acc and mem_addr[1:0] == 0: latch bus_addr = {mem_addr[31:2], 2'b00}, bus_we = mem_wen, bus_wdata = mem_dout; set bus_req = 1; clear the counter; go to BUSY.
  - If acc and misaligned: no bus access; set err_misalign; mem_din <= 0; go to DONE.
- BUSY:
  - mem_stall = 1; the counter increments each cycle.
  - On bus_ack: bus_req <= 0. For a read, mem_din <= (bus_err ? 0 : bus_rdata). Set err_bus if bus_err. Go to DONE.
  - Else, if the counter == TIMEOUT-1: bus_req <= 0; set err_timeout; mem_din <= 0 for a read; go to DONE.
- DONE:
  - mem_stall = 0. The pipeline advances on this edge and WB captures mem_din.
  - Go to IDLE unconditionally. The next MEM instruction is evaluated in the following cycle.
- mem_din holds its last value in all other cycles. Writes never modify mem_din.
- Latency: with bus_ack in the first BUSY cycle, stall lasts 2 cycles (IDLE + BUSY) and data is valid in DONE. Each extra wait cycle adds 1.
- bus_addr, bus_we and bus_wdata are stable for the whole time bus_req is high.
- bus_ack seen in IDLE or DONE is ignored.
- Sticky err_* flags clear only on reset.

Optional Feature:
- Macro: DMEM_HIT_BUF_EN.
- When defined, the block holds a single-entry load buffer: buf_valid, buf_addr[31:2] and buf_data, all reset to 0.
- Load hit: in IDLE, a load with buf_valid and mem_addr[31:2] == buf_addr produces no stall and no bus access; mem_din = buf_data combinationally in that cycle; state stays IDLE.
- Buffer refill: every successful bus read refills the buffer.
- Writes: a successful write to buf_addr updates buf_data with the write data (write-through; the bus access still occurs).
- Errors: a bus error or timeout on any access clears buf_valid.
- When not defined, every load takes the bus path, and mem_din is always the registered value.

Test Plan:
- Load to 0x0000_0010, bus_ack in the first BUSY cycle with rdata 0x1234_5678 -> mem_stall high for 2 cycles; bus_addr = 0x10, bus_we = 0; mem_din = 0x1234_5678 in DONE.
- Store 0xCAFE_F00D to 0x20 with ack after 3 wait cycles -> bus_we = 1, bus_wdata = 0xCAFE_F00D held stable; stall lasts 5 cycles; mem_din unchanged.
- Load to 0x0000_0013 -> no bus_req; err_misalign = 1; mem_din = 0; stall 1 cycle.
- Load with no ack, TIMEOUT = 16 -> bus_req high for 16 cycles then drops; err_timeout = 1; mem_din = 0; pipeline resumes.
- Load ack with bus_err = 1 -> err_bus = 1, mem_din = 0. Separately, rst_n pulsed low while in BUSY -> bus_req = 0 immediately; state IDLE; a late ack is ignored.
- DMEM_HIT_BUF_EN: two back-to-back loads to 0x40 (rdata 0xAAAA_0001) -> the second has zero stall and mem_din = 0xAAAA_0001. Then store 0x5 to 0x40 followed by a load -> the load returns 0x5 without stall.

Source files
------------

// File: rtl/dmem_bridge.sv
// dmem_bridge: MEM-stage data-memory access unit. Turns the pipeline's
// MEM request into a registered req/ack bus transaction and stalls meanwhile.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   mem_valid/ren/wen    MEM-stage access request
//   mem_addr, mem_dout   byte address and store data
//   mem_din              load data for WB capture
//   mem_stall            freeze IF..MEM while the access is incomplete
//   bus_req/we/addr/wdata registered bus request
//   bus_ack/rdata/err    bus completion, read data and error
//   err_misalign/bus/timeout  sticky error flags
//
// Optional: define DMEM_HIT_BUF_EN for a single-entry load hit buffer.
module dmem_bridge #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,
    output logic        err_misalign,
    output logic        err_bus,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      din_q;
    logic             acc;
    logic             mis;
    logic             hit;

    assign acc = mem_valid & (mem_ren | mem_wen);
    assign mis = mem_addr[1:0] != 2'b00;

`ifdef DMEM_HIT_BUF_EN
    logic        buf_valid;
    logic [29:0] buf_addr;
    logic [31:0] buf_data;

    // Aligned pure load to the buffered word completes in IDLE.
    assign hit = (state == IDLE) & acc & ~mem_wen & ~mis
               & buf_valid & (mem_addr[31:2] == buf_addr);

    assign mem_din = hit ? buf_data : din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (state == BUSY) begin
            if (bus_ack) begin
                if (bus_err) begin
                    buf_valid <= 1'b0;
                end else if (!bus_we) begin
                    buf_valid <= 1'b1;
                    buf_addr  <= bus_addr[31:2];
                    buf_data  <= bus_rdata;
                end else if (bus_addr[31:2] == buf_addr) begin
                    buf_data  <= bus_wdata;
                end
            end else if (cnt == CNT_LAST) begin
                buf_valid <= 1'b0;
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign mem_din = din_q;
`endif

    always_comb begin
        mem_stall = 1'b0;
        unique case (state)
            IDLE:    mem_stall = acc & ~hit;
            BUSY:    mem_stall = 1'b1;
            default: mem_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            din_q        <= '0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            err_misalign <= 1'b0;
            err_bus      <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc && !hit) begin
                        if (!mis) begin
                            bus_addr  <= {mem_addr[31:2], 2'b00};
                            bus_we    <= mem_wen;
                            bus_wdata <= mem_dout;
                            bus_req   <= 1'b1;
                            cnt       <= '0;
                            state     <= BUSY;
                        end else begin
                            err_misalign <= 1'b1;
                            // stores leave the load data alone
                            if (!mem_wen) din_q <= '0;
                            state <= DONE;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we)
                            din_q <= bus_err ? 32'h0 : bus_rdata;
                        if (bus_err) err_bus <= 1'b1;
                        state <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        bus_req     <= 1'b0;
                        err_timeout <= 1'b1;
                        if (!bus_we) din_q <= '0;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
